// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath blocks.
// Used by the BCD-to-binary converter and its digit adjust cell.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } conv_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ       = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double dabble.
// After a right shift, a digit of 8 or more is pulled back down by 3.
module bcd_digit_adjust
  import calc_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] result
);

  assign result = (digit >= 4'd8) ? (digit - BCD_ADJ) : digit;

endmodule

// File: rtl/bcd_to_unsigned.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// One bit of the binary result is produced per CONVERT cycle.
module bcd_to_unsigned
  import calc_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int BIN_W    = 4 * N_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic                  idle,
  output logic                  valid,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_W - 1);

  conv_state_t      state;
  conv_state_t      state_next;
  logic [SR_W-1:0]  shift_reg;
  logic [SR_W-1:0]  shifted;
  logic [BCD_W-1:0] bcd_adjusted;
  logic [CNT_W-1:0] count;
  logic             digit_bad;
  logic             input_bad;

  // Any non-decimal digit poisons the whole operand.
  always_comb begin
    input_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) begin
        input_bad = 1'b1;
      end
    end
  end

  assign shifted = shift_reg >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit  (shifted[BIN_W + 4*g +: 4]),
      .result (bcd_adjusted[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = CONVERT;
      CONVERT: if (count == LAST_COUNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; valid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      count     <= '0;
      digit_bad <= 1'b0;
      valid     <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            shift_reg <= {bcd_in, {BIN_W{1'b0}}};
            digit_bad <= input_bad;
            count     <= '0;
          end
        end
        CONVERT: begin
          shift_reg <= {bcd_adjusted, shifted[BIN_W-1:0]};
          count     <= count + CNT_W'(1);
        end
        DONE: begin
          valid <= 1'b1;
          if (digit_bad) begin
            bin_out <= '0;
            err     <= 1'b1;
          end else begin
            bin_out <= shift_reg[BIN_W-1:0];
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign idle = (state == IDLE);

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed self-checking bench for bcd_to_unsigned with default parameters.
module tb_bcd_to_unsigned;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [31:0] bcd_in;
  logic        idle;
  logic        valid;
  logic [31:0] bin_out;
  logic        err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_to_unsigned #(.N_DIGITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd_in  (bcd_in),
    .idle    (idle),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one conversion and wait (bounded) for its valid pulse.
  task automatic run_conv(input logic [31:0] bcd, output int lat,
                          output logic [31:0] bin, output logic e,
                          output logic idl, output int busy_idle,
                          output logic valid_after);
    bcd_in  = bcd;
    trigger = 1'b1;
    tick();
    trigger   = 1'b0;
    lat       = 1;
    busy_idle = 0;
    while (!valid && lat < 100) begin
      if (idle) busy_idle++;
      tick();
      lat++;
    end
    bin = bin_out;
    e   = err;
    idl = idle;
    tick();
    valid_after = valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; trigger = 1'b0; bcd_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++; if (idle !== 1'b1) $display("[TB] FAIL reset_idle: got %b expected 1", idle); else passed++;
    total++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid); else passed++;
    total++; if (bin_out !== 32'h0) $display("[TB] FAIL reset_bin: got %h expected 0", bin_out); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else passed++;
  endtask

  task automatic test_basic();
    int lat, bi; logic [31:0] b; logic e, idl, va;
    run_conv(32'h0000_1234, lat, b, e, idl, bi, va);
    total++; if (lat !== 34) $display("[TB] FAIL basic_latency: got %0d expected 34", lat); else passed++;
    total++; if (b !== 32'h0000_04D2) $display("[TB] FAIL basic_bin: got %h expected 000004d2", b); else passed++;
    total++; if (e !== 1'b0) $display("[TB] FAIL basic_err: got %b expected 0", e); else passed++;
    total++; if (idl !== 1'b1) $display("[TB] FAIL basic_idle_at_valid: got %b expected 1", idl); else passed++;
    total++; if (bi !== 0) $display("[TB] FAIL basic_idle_while_busy: got %0d cycles expected 0", bi); else passed++;
    total++; if (va !== 1'b0) $display("[TB] FAIL basic_valid_pulse_width: got %b expected 0", va); else passed++;
  endtask

  task automatic test_values();
    logic [31:0] vin  [4] = '{32'h9999_9999, 32'h0006_5535, 32'h0000_0000, 32'h0000_2025};
    logic [31:0] vexp [4] = '{32'h05F5_E0FF, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_07E9};
    int lat, bi; logic [31:0] b; logic e, idl, va;
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], lat, b, e, idl, bi, va);
      total++; if (b !== vexp[i]) $display("[TB] FAIL value_bin[%0d]: got %h expected %h", i, b, vexp[i]); else passed++;
      total++; if (e !== 1'b0) $display("[TB] FAIL value_err[%0d]: got %b expected 0", i, e); else passed++;
      total++; if (lat !== 34) $display("[TB] FAIL value_latency[%0d]: got %0d expected 34", i, lat); else passed++;
    end
  endtask

  task automatic test_invalid();
    int lat, bi; logic [31:0] b; logic e, idl, va;
    run_conv(32'h0000_001A, lat, b, e, idl, bi, va);
    total++; if (lat !== 34) $display("[TB] FAIL invalid_latency: got %0d expected 34", lat); else passed++;
    total++; if (b !== 32'h0) $display("[TB] FAIL invalid_bin: got %h expected 0", b); else passed++;
    total++; if (e !== 1'b1) $display("[TB] FAIL invalid_err: got %b expected 1", e); else passed++;
    total++; if (err !== 1'b1) $display("[TB] FAIL invalid_err_hold: got %b expected 1", err); else passed++;
    run_conv(32'h0000_0042, lat, b, e, idl, bi, va);
    total++; if (b !== 32'd42) $display("[TB] FAIL recover_bin: got %h expected 0000002a", b); else passed++;
    total++; if (e !== 1'b0) $display("[TB] FAIL recover_err: got %b expected 0", e); else passed++;
  endtask

  task automatic test_busy_trigger();
    int valids = 0, vcycle = 0, idle_bad = 0;
    logic [31:0] vbin = '0;
    bcd_in  = 32'h0000_1234;
    trigger = 1'b1;
    tick();
    for (int n = 1; n <= 80; n++) begin
      trigger = (n == 5);
      if (n == 5) bcd_in = 32'h0000_0777;
      if (valid) begin
        valids++;
        vbin   = bin_out;
        vcycle = n;
      end
      if (n < 34 && idle) idle_bad++;
      tick();
    end
    trigger = 1'b0;
    total++; if (valids !== 1) $display("[TB] FAIL busy_valid_count: got %0d expected 1", valids); else passed++;
    total++; if (vbin !== 32'h0000_04D2) $display("[TB] FAIL busy_bin: got %h expected 000004d2", vbin); else passed++;
    total++; if (vcycle !== 34) $display("[TB] FAIL busy_latency: got %0d expected 34", vcycle); else passed++;
    total++; if (idle_bad !== 0) $display("[TB] FAIL busy_idle: got %0d idle cycles expected 0", idle_bad); else passed++;
  endtask

  task automatic test_reset_mid();
    int valids = 0;
    bcd_in  = 32'h0000_1234;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (idle !== 1'b1) $display("[TB] FAIL abort_idle: got %b expected 1", idle); else passed++;
    total++; if (bin_out !== 32'h0) $display("[TB] FAIL abort_bin: got %h expected 0", bin_out); else passed++;
    total++; if (err !== 1'b0) $display("[TB] FAIL abort_err: got %b expected 0", err); else passed++;
    for (int n = 0; n < 40; n++) begin
      if (valid) valids++;
      tick();
    end
    total++; if (valids !== 0) $display("[TB] FAIL abort_no_valid: got %0d expected 0", valids); else passed++;

    bcd_in  = 32'h0000_0055;
    reset   = 1'b1;
    trigger = 1'b1;
    tick();
    reset   = 1'b0;
    trigger = 1'b0;
    total++; if (idle !== 1'b1) $display("[TB] FAIL reset_beats_trigger: got idle %b expected 1", idle); else passed++;
    valids = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid) valids++;
      tick();
    end
    total++; if (valids !== 0) $display("[TB] FAIL reset_beats_trigger_valid: got %0d expected 0", valids); else passed++;
  endtask

  task automatic test_back_to_back();
    int valids = 0, last = 0, bad_gap = 0, bad_bin = 0;
    bcd_in  = 32'h0000_2025;
    trigger = 1'b1;
    tick();
    for (int n = 1; n <= 140; n++) begin
      if (valid) begin
        valids++;
        if (n - last != 34) bad_gap++;
        if (bin_out !== 32'h0000_07E9) bad_bin++;
        last = n;
      end
      tick();
    end
    trigger = 1'b0;
    repeat (40) tick();
    total++; if (valids !== 4) $display("[TB] FAIL b2b_valid_count: got %0d expected 4", valids); else passed++;
    total++; if (bad_gap !== 0) $display("[TB] FAIL b2b_spacing: got %0d bad gaps expected 0", bad_gap); else passed++;
    total++; if (bad_bin !== 0) $display("[TB] FAIL b2b_bin: got %0d wrong results expected 0", bad_bin); else passed++;
  endtask

  initial begin
    reset   = 1'b1;
    trigger = 1'b0;
    bcd_in  = '0;
    test_reset();
    test_basic();
    test_values();
    test_invalid();
    test_busy_trigger();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
